// File: rtl/param_bank_pkg.sv
// param_bank_pkg: shared row type, FSM states and default sizes for the parameter bank.
package param_bank_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int LANES_DEF      = 16;
  localparam int DEPTH_DEF      = 64;

  typedef logic signed [DATA_WIDTH_DEF-1:0] param_t;
  typedef param_t [LANES_DEF-1:0] row_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

endpackage

// File: rtl/param_bank_mem.sv
// param_bank_mem: DEPTH-row register file, single write port, combinational read port.
// Rows at or beyond DEPTH are never written and always read back as zero.
module param_bank_mem
  import param_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0]            rd_addr,
  output logic [LANES-1:0][DATA_WIDTH-1:0] rd_data
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

  logic [LANES-1:0][DATA_WIDTH-1:0] mem_q [DEPTH];
  logic wr_in_range;
  logic rd_in_range;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_A;
  assign rd_in_range = {1'b0, rd_addr} < DEPTH_A;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && wr_in_range) begin
      mem_q[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Reads see pre-edge contents, so a same-cycle write to the row is not visible.
  assign rd_data = rd_in_range ? mem_q[rd_addr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/param_bank_burst.sv
// param_bank_burst: writable parameter bank serving row bursts over valid/ready.
// Defining PARAM_BANK_RANGE_ERR_EN adds out_err / err_sticky range-error outputs.
module param_bank_burst
  import param_bank_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wr_en,
  input  logic [ADDR_WIDTH-1:0]            wr_addr,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  input  logic [LEN_WIDTH-1:0]             req_len,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0]            out_row,
  output logic                             out_last
`ifdef PARAM_BANK_RANGE_ERR_EN
  ,
  output logic                             out_err,
  output logic                             err_sticky
`endif
);

  // state | meaning
  // IDLE  | accepts a request; the last beat of a prior burst may still be held
  // BURST | loads one row per free output slot until remaining reaches zero

  state_t                           state_q, state_d;
  logic [ADDR_WIDTH-1:0]            row_ptr_q, row_ptr_d;
  logic [LEN_WIDTH-1:0]             remaining_q, remaining_d;
  logic                             out_valid_q, out_valid_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0]            out_row_q, out_row_d;
  logic                             out_last_q, out_last_d;
  logic [LANES-1:0][DATA_WIDTH-1:0] rd_data;
  logic                             slot_free;
  logic                             load;

  param_bank_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .LANES      (LANES),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (row_ptr_q),
    .rd_data (rd_data)
  );

  assign slot_free = !out_valid_q || out_ready;
  assign load      = (state_q == BURST) && slot_free;

  always_comb begin
    state_d     = state_q;
    row_ptr_d   = row_ptr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    req_ready   = (state_q == IDLE);

    if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          row_ptr_d   = req_addr;
          remaining_d = req_len;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (load) begin
          out_valid_d = 1'b1;
          out_data_d  = rd_data;
          out_row_d   = row_ptr_q;
          out_last_d  = (remaining_q == '0);
          row_ptr_d   = row_ptr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      row_ptr_q   <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_ptr_q   <= row_ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;

`ifdef PARAM_BANK_RANGE_ERR_EN
  localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

  logic out_err_q, out_err_d;
  logic err_sticky_q, err_sticky_d;

  always_comb begin
    out_err_d    = out_err_q;
    err_sticky_d = err_sticky_q;
    if (slot_free) out_err_d = 1'b0;
    if (load) begin
      out_err_d    = {1'b0, row_ptr_q} >= DEPTH_A;
      err_sticky_d = err_sticky_q | out_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_err_q    <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      out_err_q    <= out_err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign out_err    = out_err_q;
  assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_param_bank_burst.sv
// tb_param_bank_burst: self-checking bench for param_bank_burst with a row-level reference model.
module tb_param_bank_burst;
  import param_bank_pkg::*;

  localparam int AW    = 8;
  localparam int LW    = 4;
  localparam int DEPTH = DEPTH_DEF;

  logic           clk = 1'b0;
  logic           rst;
  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  row_t           wr_data;
  logic           req_valid;
  logic           req_ready;
  logic [AW-1:0]  req_addr;
  logic [LW-1:0]  req_len;
  logic           out_valid;
  logic           out_ready;
  row_t           out_data;
  logic [AW-1:0]  out_row;
  logic           out_last;
`ifdef PARAM_BANK_RANGE_ERR_EN
  logic           out_err;
  logic           err_sticky;
`endif

  always #5 clk = ~clk;

  param_bank_burst dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last)
`ifdef PARAM_BANK_RANGE_ERR_EN
    ,
    .out_err   (out_err),
    .err_sticky(err_sticky)
`endif
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  row_t model_mem [DEPTH];
  row_t last_data;

  typedef struct {
    row_t          data;
    logic [AW-1:0] row;
    logic          last;
  } beat_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    val;
    logic [7:0]    exp;
  } vec_t;

  task automatic check(input bit ok, input string name, input string act, input string exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %s, expected %s", name, act, exp);
  endtask

  function automatic row_t model_read(input logic [AW-1:0] r);
    int idx = int'(r);
    if (idx < DEPTH) return model_mem[idx];
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input row_t d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    if (int'(a) < DEPTH) model_mem[int'(a)] = d;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0 per presented beat, 2: random ready
  task automatic run_burst(input logic [AW-1:0] a, input logic [LW-1:0] len, input int mode);
    beat_t exp_q[$];
    beat_t b;
    beat_t prev;
    int    w = 0;
    int    cyc = 0;
    int    pidx = 0;
    int    first_valid = -1;
    bit    stalled = 1'b0;
    bit    rdy;
    for (int k = 0; k <= int'(len); k++) begin
      b.row  = AW'(int'(a) + k);
      b.data = model_read(b.row);
      b.last = (k == int'(len));
      exp_q.push_back(b);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = len;
    while (!req_ready && w < 50) begin
      tick();
      w++;
    end
    check(req_ready == 1'b1, "req_ready_idle", $sformatf("%0b", req_ready), "1");
    tick();
    req_valid = 1'b0;
    check(req_ready == 1'b0, "req_ready_busy", $sformatf("%0b", req_ready), "0");
    while (exp_q.size() > 0 && cyc < 200) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (stalled)
        check(out_valid && out_data == prev.data && out_row == prev.row && out_last == prev.last,
              "stall_hold",
              $sformatf("v=%0b row=%0d last=%0b data=%h", out_valid, out_row, out_last, out_data),
              $sformatf("v=1 row=%0d last=%0b data=%h", prev.row, prev.last, prev.data));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (pidx % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      out_ready = rdy;
      if (out_valid) pidx++;
      if (out_valid && rdy) begin
        b = exp_q.pop_front();
        check(out_data == b.data && out_row == b.row && out_last == b.last, "beat",
              $sformatf("row=%0d last=%0b data=%h", out_row, out_last, out_data),
              $sformatf("row=%0d last=%0b data=%h", b.row, b.last, b.data));
`ifdef PARAM_BANK_RANGE_ERR_EN
        check(out_err == (int'(b.row) >= DEPTH), "out_err",
              $sformatf("%0b", out_err), $sformatf("%0b", int'(b.row) >= DEPTH));
`endif
        last_data = out_data;
      end
      stalled   = out_valid && !rdy;
      prev.data = out_data;
      prev.row  = out_row;
      prev.last = out_last;
      tick();
      cyc++;
    end
    out_ready = 1'b1;
    check(exp_q.size() == 0, "burst_complete", $sformatf("%0d left", exp_q.size()), "0 left");
    check(first_valid == 1, "first_beat_latency", $sformatf("%0d", first_valid), "1");
    check(out_valid == 1'b0 && req_ready == 1'b1, "burst_end",
          $sformatf("valid=%0b ready=%0b", out_valid, req_ready), "valid=0 ready=1");
  endtask

  initial begin
    vec_t  vecs[6];
    row_t  d;
    row_t  old7;
    logic [AW-1:0] ra;

    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    req_valid = 1'b0; req_addr = '0; req_len = '0; out_ready = 1'b1;
    clear_model();
    tick();
    rst = 1'b0;
    check(out_valid == 0 && req_ready == 1 && out_row == 0 && out_data == '0 && out_last == 0,
          "reset_state",
          $sformatf("v=%0b rdy=%0b row=%0d last=%0b data=%h", out_valid, req_ready, out_row, out_last, out_data),
          "v=0 rdy=1 row=0 last=0 data=0");
`ifdef PARAM_BANK_RANGE_ERR_EN
    check(out_err == 0 && err_sticky == 0, "err_reset",
          $sformatf("%0b%0b", out_err, err_sticky), "00");
`endif

    run_burst(8'd0, 4'd0, 0);

    for (int i = 0; i < 16; i++) d[i] = 8'(i + 1);
    do_write(8'd3, d);
    for (int i = 0; i < 16; i++) d[i] = 8'(i + 17);
    do_write(8'd4, d);
    for (int i = 0; i < 16; i++) d[i] = 8'(-(i + 1));
    do_write(8'd5, d);
    run_burst(8'd3, 4'd2, 0);
    check(last_data[15] == 8'hF0, "row5_lane15", $sformatf("%h", last_data[15]), "f0");
    run_burst(8'd3, 4'd2, 1);

    vecs[0] = '{addr: 8'd0,   val: 8'h5A, exp: 8'h5A};
    vecs[1] = '{addr: 8'd63,  val: 8'hA5, exp: 8'hA5};
    vecs[2] = '{addr: 8'd64,  val: 8'h77, exp: 8'h00};
    vecs[3] = '{addr: 8'd200, val: 8'h33, exp: 8'h00};
    vecs[4] = '{addr: 8'd255, val: 8'h80, exp: 8'h00};
    vecs[5] = '{addr: 8'd7,   val: 8'hFE, exp: 8'hFE};
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 16; i++) d[i] = vecs[v].val;
      do_write(vecs[v].addr, d);
      run_burst(vecs[v].addr, 4'd0, 0);
      check(last_data[0] == vecs[v].exp, $sformatf("vec%0d_lane0", v),
            $sformatf("%h", last_data[0]), $sformatf("%h", vecs[v].exp));
    end

    run_burst(8'd62, 4'd3, 0);
`ifdef PARAM_BANK_RANGE_ERR_EN
    check(err_sticky == 1'b1, "err_sticky_set", $sformatf("%0b", err_sticky), "1");
`endif

    // Write row 7 on the same edge that loads its beat: the beat must carry the old row.
    old7 = model_mem[7];
    req_valid = 1'b1; req_addr = 8'd7; req_len = 4'd0;
    tick();
    req_valid = 1'b0;
    d = '0;
    d[0] = 8'h11;
    do_write(8'd7, d);
    check(out_valid == 1'b1 && out_data == old7, "rbw_old",
          $sformatf("v=%0b data=%h", out_valid, out_data), $sformatf("v=1 data=%h", old7));
    tick();
    run_burst(8'd7, 4'd0, 0);
    check(last_data[0] == 8'h11, "rbw_new", $sformatf("%h", last_data[0]), "11");

    for (int it = 0; it < 25; it++) begin
      for (int k = 0; k < int'($urandom_range(0, 4)); k++) begin
        for (int i = 0; i < 16; i++) d[i] = 8'($urandom);
        do_write(8'($urandom_range(0, 80)), d);
      end
      ra = (it % 5 == 4) ? 8'($urandom_range(246, 255)) : 8'($urandom_range(0, 70));
      run_burst(ra, 4'($urandom_range(0, 15)), 2);
    end
`ifdef PARAM_BANK_RANGE_ERR_EN
    check(err_sticky == 1'b1, "err_sticky_hold", $sformatf("%0b", err_sticky), "1");
`endif

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++) d[i] = 8'(r * 16 + i + 1);
      do_write(8'(r), d);
    end
    out_ready = 1'b1;
    req_valid = 1'b1; req_addr = 8'd0; req_len = 4'd7;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check(out_valid == 1'b1 && out_row == 8'd1, "pre_reset_beat",
          $sformatf("v=%0b row=%0d", out_valid, out_row), "v=1 row=1");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_model();
    check(out_valid == 0 && req_ready == 1 && out_row == 0 && out_last == 0 && out_data == '0,
          "mid_burst_reset",
          $sformatf("v=%0b rdy=%0b row=%0d last=%0b", out_valid, req_ready, out_row, out_last),
          "v=0 rdy=1 row=0 last=0");
`ifdef PARAM_BANK_RANGE_ERR_EN
    check(err_sticky == 1'b0, "err_sticky_clear", $sformatf("%0b", err_sticky), "0");
`endif
    tick();
    tick();
    check(out_valid == 1'b0, "no_beats_after_reset", $sformatf("%0b", out_valid), "0");
    run_burst(8'd0, 4'd7, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_bank_burst.md
Name: param_bank_burst

Overview:
- Parametrised, writable successor to the fixed weight/bias lookup tables. Holds DEPTH rows of LANES signed DATA_WIDTH-bit parameters.
- Rows are loaded at runtime through a write port.
- Serves burst reads (start row plus length) over a valid/ready stream, one full row per beat.
- Sits between the parameter loader and the transformer datapath (embedding, attention, MLP bias/weight consumers).

Parameters:
- DATA_WIDTH, 8, bits per signed parameter.
- LANES, 16, parameters per row (output vector width).
- DEPTH, 64, number of stored rows; must be ≤ 2**ADDR_WIDTH.
- ADDR_WIDTH, 8, row address width.
- LEN_WIDTH, 4, burst length field width; burst is req_len+1 rows (1..2**LEN_WIDTH).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write one row this cycle.
- wr_addr  in  ADDR_WIDTH  row to write.
- wr_data  in  LANES x DATA_WIDTH signed  row contents.
- req_valid  in  1  burst request valid.
- req_ready  out  1  engine can accept a request.
- req_addr  in  ADDR_WIDTH  first row of burst.
- req_len  in  LEN_WIDTH  rows minus one.
- out_valid  out  1  out_data holds a row.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  LANES x DATA_WIDTH signed  row contents.
- out_row  out  ADDR_WIDTH  row index of the current beat.
- out_last  out  1  final beat of the burst.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All storage rows cleared to 0; FSM goes to IDLE.
  - req_ready=1; out_valid=0, out_last=0, out_data=0, out_row=0.
  - Reset mid-burst aborts the burst immediately; no further beats are produced.
- Write port:
  - Always accepted. When wr_addr<DEPTH, row wr_addr is updated at the clock edge.
  - Writes with wr_addr≥DEPTH are ignored.
- FSM states: IDLE, BURST.
  - IDLE: req_ready=1. A handshake (req_valid & req_ready) latches req_addr into row_ptr and req_len into remaining, then moves to BURST.
  - BURST: req_ready=0. A beat is loaded into the output register when out_valid=0 or out_ready=1 ("slot free").
  - Each loaded beat: out_data=mem[row_ptr], out_row=row_ptr, out_last=(remaining==0). Then row_ptr increments and remaining decrements.
  - After the last beat is loaded, the FSM returns to IDLE.
  - Back-to-back bursts: the first beat of the next burst appears on the cycle after its handshake.
- Latency and throughput:
  - Handshake at edge N gives out_valid=1 with the first row after edge N+1.
  - One beat per cycle while out_ready=1.
  - When out_ready=0, out_data, out_row and out_last hold stable and the FSM stalls.
  - out_valid drops after the last beat is consumed, unless a new beat is loaded in the same cycle.
- Boundaries:
  - row_ptr wraps modulo 2**ADDR_WIDTH.
  - Rows ≥DEPTH read as all zeros.
  - Same-cycle write and beat load of the same row: the beat captures the OLD contents (read-before-write).
  - The new request is not accepted until the FSM is back in IDLE; req_valid may be held, and req fields must remain stable while req_valid=1 and req_ready=0.
- Arithmetic: no arithmetic on data. Values are stored and returned bit-exact, signed two's complement.

Optional Feature:
- Macro: PARAM_BANK_RANGE_ERR_EN.
- When defined:
  - Adds output out_err (1 bit), aligned with out_valid; it is 1 when out_row≥DEPTH.
  - Adds sticky output err_sticky: set by any such beat, cleared only by rst.
  - Both outputs reset to 0.
- When undefined: neither port exists; out-of-range rows silently return zeros.

Decomposition:
- Shared package param_bank_pkg holds:
  - typedef row_t, a packed array [LANES] of signed [DATA_WIDTH].
  - enum state_t {IDLE, BURST}.
  - default constants for DATA_WIDTH, LANES, DEPTH.
- One natural sub-module: param_bank_mem.
  - Register array with a write port and a combinational read port.
  - Synchronous clear on rst; zero returned for out-of-range addresses.
  - The top holds the FSM and the output register.

Test Plan:
- Reset, then request addr=0, len=0 → one beat: out_data all zeros, out_row=0, out_last=1; req_ready returns to 1 one cycle later.
- Write rows 3..5 with lane i = i+1, i = i+17 and -(i+1) (8'hFF..8'hF0). Request addr=3, len=2 with out_ready=1 → three consecutive beats:
  - rows 3,4,5 with the written data;
  - out_last only on row 5;
  - first beat one cycle after the handshake.
- Same burst with out_ready toggling 1,0,0,1,… → no beat lost or duplicated; data held stable while stalled.
- DEPTH=64: request addr=62, len=3 → rows 62, 63, then 64 and 65 as zeros.
  - With PARAM_BANK_RANGE_ERR_EN: out_err=1 on the last two beats; err_sticky stays 1 until rst.
- Write row 7 (lane0=8'h11) on the same cycle beat row 7 is loaded → beat shows the old value; a subsequent read shows 8'h11.
- Assert rst during beat 2 of a len=7 burst → out_valid=0 on the next cycle; req_ready=1; storage reads back zero.
